// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch/timer core: controller states,
// blank segment pattern and BCD to 7-segment decode.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StRun,
        StPaused,
        StDone,
        StAdjust
    } sw_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high {g..a}; non-BCD nibbles decode to all-off.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with its own wrap limit; carry/borrow outputs are
// combinational so a whole chain of cells settles within one cycle.
module bcd_digit_cell (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] max_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic       load_zero_i,
    input  logic       load_max_i,
    output logic [3:0] value_o,
    output logic       carry_o,
    output logic       borrow_o
);

    logic [3:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_zero_i) begin
            value_d = 4'd0;
        end else if (load_max_i) begin
            value_d = max_i;
        end else if (inc_i) begin
            value_d = (value_q == max_i) ? 4'd0 : value_q + 4'd1;
        end else if (dec_i) begin
            value_d = (value_q == 4'd0) ? max_i : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign carry_o  = inc_i && (value_q == max_i);
    assign borrow_o = dec_i && (value_q == 4'd0);

endmodule

// File: rtl/stopwatch_timer_core.sv
// Multi-digit BCD up/down timer with pause, clear, per-field adjust and a
// multiplexed active-low 7-segment scan output.
module stopwatch_timer_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned           N_DIGITS  = 4,
    parameter logic [4*N_DIGITS-1:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9},
    parameter bit                    WRAP      = 1'b0,
    parameter int unsigned           SEL_W     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick_count_i,
    input  logic                  tick_adj_i,
    input  logic                  scan_tick_i,
    input  logic                  blink_lvl_i,
    input  logic                  pause_tgl_i,
    input  logic                  clear_i,
    input  logic                  adj_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  dir_i,
    output logic [4*N_DIGITS-1:0] digits_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic                  rollover_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic [6:0]            seg_o
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    sw_state_e state_q, state_d, saved_q, saved_d, base_st, saved_st;
    logic      rollover_q, rollover_d;
    logic      cnt_up, cnt_dn, wrap_up, wrap_dn, adj_fire;
    logic      at_max_all, at_zero_all;

    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   inc, dec, carry, borrow, inc_ch, dec_ch;
    logic                  unused_chain_top;

    assign at_max_all  = (digits == DIGIT_MAX);
    assign at_zero_all = (digits == '0);

    always_comb begin
        state_d    = state_q;
        saved_d    = saved_q;
        rollover_d = 1'b0;
        cnt_up     = 1'b0;
        cnt_dn     = 1'b0;
        wrap_up    = 1'b0;
        wrap_dn    = 1'b0;
        adj_fire   = 1'b0;
        base_st    = state_q;
        saved_st   = saved_q;
        // Clear releases DONE, both live and as the state parked during adjust.
        if (clear_i) begin
            if (base_st == StDone) base_st = StPaused;
            if (saved_st == StDone) saved_st = StPaused;
        end
        if (adj_i) begin
            if (state_q != StAdjust) begin
                state_d = StAdjust;
                saved_d = base_st;
            end else begin
                saved_d  = saved_st;
                adj_fire = tick_adj_i && !clear_i;
            end
        end else if (state_q == StAdjust) begin
            state_d = (saved_st == StDone) ? StPaused : saved_st;
        end else if (clear_i) begin
            state_d = base_st;
        end else if (pause_tgl_i) begin
            state_d = (state_q == StRun) ? StPaused : StRun;
        end else if (tick_count_i && (state_q == StRun)) begin
            if (!dir_i) begin
                if (!at_max_all) begin
                    cnt_up = 1'b1;
                end else if (WRAP) begin
                    wrap_up    = 1'b1;
                    rollover_d = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end else begin
                if (!at_zero_all) begin
                    cnt_dn = 1'b1;
                end else if (WRAP) begin
                    wrap_dn    = 1'b1;
                    rollover_d = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
        end
    end

    assign inc_ch           = {carry[N_DIGITS-2:0], cnt_up};
    assign dec_ch           = {borrow[N_DIGITS-2:0], cnt_dn};
    assign unused_chain_top = carry[N_DIGITS-1] ^ borrow[N_DIGITS-1];

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        localparam int F = i / 2;
        logic       sel_hit, field_max;
        logic [3:0] max_w;

        assign sel_hit   = adj_fire && (int'(sel_i) == F);
        assign field_max = (digits[8*F +: 8] == DIGIT_MAX[8*F +: 8]);

        if ((i % 2) == 0) begin : g_lo
            // During adjust the low digit counts 0..9 so the pair steps as decimal.
            assign inc[i] = adj_fire ? (sel_hit && !field_max) : inc_ch[i];
            assign max_w  = adj_fire ? 4'd9 : DIGIT_MAX[4*i +: 4];
        end else begin : g_hi
            assign inc[i] = inc_ch[i];
            assign max_w  = DIGIT_MAX[4*i +: 4];
        end
        assign dec[i] = dec_ch[i];

        bcd_digit_cell u_cell (
            .clk         (clk),
            .reset       (reset),
            .max_i       (max_w),
            .inc_i       (inc[i]),
            .dec_i       (dec[i]),
            .load_zero_i (clear_i || wrap_up || (sel_hit && field_max)),
            .load_max_i  (wrap_dn),
            .value_o     (digits[4*i +: 4]),
            .carry_o     (carry[i]),
            .borrow_o    (borrow[i])
        );
    end

    logic [IDX_W-1:0]    idx_q, idx_d, idx_new;
    logic [N_DIGITS-1:0] an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                blank;

    always_comb begin
        idx_d   = idx_q;
        an_d    = an_q;
        seg_d   = seg_q;
        idx_new = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        blank   = adj_i && blink_lvl_i && ((int'(idx_new) / 2) == int'(sel_i));
        if (scan_tick_i) begin
            idx_d = idx_new;
            an_d  = ~(N_DIGITS'(1) << idx_new);
            seg_d = blank ? SEG_BLANK : ~seg_decode(digits[{idx_new, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StRun;
            saved_q    <= StRun;
            rollover_q <= 1'b0;
            idx_q      <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            saved_q    <= saved_d;
            rollover_q <= rollover_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign digits_o   = digits;
    assign running_o  = (state_q == StRun);
    assign done_o     = (state_q == StDone);
    assign rollover_o = rollover_q;
    assign an_o       = an_q;
    assign seg_o      = seg_q;

endmodule

// File: tb/tb_stopwatch_timer_core.sv
// Bench for stopwatch_timer_core: a stop-at-terminal and a wrapping instance
// share stimulus and are checked every cycle against a mixed-radix count model.
module tb_stopwatch_timer_core;

    localparam int N     = 4;
    localparam int TOTAL = 3600;
    localparam int RUN = 0, PAUSED = 1, DONE = 2, ADJ = 3;
    localparam int MAXD [4] = '{9, 5, 9, 5};
    localparam logic [6:0] SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk = 1'b0;
    logic reset, tick_count, tick_adj, scan_tick, blink_lvl, pause_tgl, clear, adj, dir;
    logic [1:0] sel;

    logic [15:0] dig0, dig1;
    logic        run0, run1, done0, done1, roll0, roll1;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;

    int n_checks = 0;
    int n_err    = 0;
    bit roll_seen;

    always #5 clk = ~clk;

    stopwatch_timer_core #(
        .N_DIGITS (4), .DIGIT_MAX (16'h5959), .WRAP (1'b0), .SEL_W (2)
    ) u_dut_stop (
        .clk (clk), .reset (reset), .tick_count_i (tick_count), .tick_adj_i (tick_adj),
        .scan_tick_i (scan_tick), .blink_lvl_i (blink_lvl), .pause_tgl_i (pause_tgl),
        .clear_i (clear), .adj_i (adj), .sel_i (sel), .dir_i (dir), .digits_o (dig0),
        .running_o (run0), .done_o (done0), .rollover_o (roll0), .an_o (an0), .seg_o (seg0)
    );

    stopwatch_timer_core #(
        .N_DIGITS (4), .DIGIT_MAX (16'h5959), .WRAP (1'b1), .SEL_W (2)
    ) u_dut_wrap (
        .clk (clk), .reset (reset), .tick_count_i (tick_count), .tick_adj_i (tick_adj),
        .scan_tick_i (scan_tick), .blink_lvl_i (blink_lvl), .pause_tgl_i (pause_tgl),
        .clear_i (clear), .adj_i (adj), .sel_i (sel), .dir_i (dir), .digits_o (dig1),
        .running_o (run1), .done_o (done1), .rollover_o (roll1), .an_o (an1), .seg_o (seg1)
    );

    // Reference model; instance 1 is the wrapping one.
    int         m_dig [2][4];
    int         m_mode [2];
    int         m_saved [2];
    bit         m_roll [2];
    int         m_idx [2];
    logic [3:0] m_an [2];
    logic [6:0] m_seg [2];

    function automatic int m_value(input int k);
        int n = 0;
        for (int i = N - 1; i >= 0; i--) n = n * (MAXD[i] + 1) + m_dig[k][i];
        return n;
    endfunction

    task automatic m_set(input int k, input int v);
        int n = v;
        for (int i = 0; i < N; i++) begin
            m_dig[k][i] = n % (MAXD[i] + 1);
            n = n / (MAXD[i] + 1);
        end
    endtask

    function automatic logic [15:0] m_pack(input int k);
        return {4'(m_dig[k][3]), 4'(m_dig[k][2]), 4'(m_dig[k][1]), 4'(m_dig[k][0])};
    endfunction

    task automatic m_step(input int k);
        int base, sv, n, f, fmod, v;
        if (reset) begin
            for (int i = 0; i < N; i++) m_dig[k][i] = 0;
            m_mode[k] = RUN; m_saved[k] = RUN; m_roll[k] = 1'b0;
            m_idx[k] = 0; m_an[k] = 4'hF; m_seg[k] = 7'h7F;
            return;
        end
        m_roll[k] = 1'b0;
        if (scan_tick) begin
            m_idx[k] = (m_idx[k] + 1) % N;
            m_an[k]  = 4'hF ^ (4'b0001 << m_idx[k]);
            if (adj && blink_lvl && (m_idx[k] / 2 == int'(sel))) m_seg[k] = 7'h7F;
            else m_seg[k] = ~SEGTAB[m_dig[k][m_idx[k]]];
        end
        base = m_mode[k];
        sv   = m_saved[k];
        if (clear) begin
            for (int i = 0; i < N; i++) m_dig[k][i] = 0;
            if (base == DONE) base = PAUSED;
            if (sv == DONE) sv = PAUSED;
        end
        if (adj) begin
            if (m_mode[k] != ADJ) begin
                m_saved[k] = base;
                m_mode[k]  = ADJ;
            end else begin
                m_saved[k] = sv;
                if (tick_adj && !clear && int'(sel) < N / 2) begin
                    f    = int'(sel);
                    fmod = MAXD[2*f+1] * 10 + MAXD[2*f] + 1;
                    v    = (m_dig[k][2*f+1] * 10 + m_dig[k][2*f] + 1) % fmod;
                    m_dig[k][2*f]   = v % 10;
                    m_dig[k][2*f+1] = v / 10;
                end
            end
        end else if (m_mode[k] == ADJ) begin
            m_mode[k] = (sv == DONE) ? PAUSED : sv;
        end else if (clear) begin
            m_mode[k] = base;
        end else if (pause_tgl) begin
            m_mode[k] = (m_mode[k] == RUN) ? PAUSED : RUN;
        end else if (tick_count && m_mode[k] == RUN) begin
            n = m_value(k);
            if (!dir) begin
                if (n != TOTAL - 1) n++;
                else if (k == 1) begin n = 0; m_roll[k] = 1'b1; end
                else m_mode[k] = DONE;
            end else begin
                if (n != 0) n--;
                else if (k == 1) begin n = TOTAL - 1; m_roll[k] = 1'b1; end
                else m_mode[k] = DONE;
            end
            m_set(k, n);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_dut(input int k, input logic [15:0] d, input logic r,
                               input logic dn, input logic ro, input logic [3:0] a,
                               input logic [6:0] s);
        check($sformatf("digits[%0d]", k), 32'(d), 32'(m_pack(k)));
        check($sformatf("running[%0d]", k), 32'(r), 32'(m_mode[k] == RUN));
        check($sformatf("done[%0d]", k), 32'(dn), 32'(m_mode[k] == DONE));
        check($sformatf("rollover[%0d]", k), 32'(ro), 32'(m_roll[k]));
        check($sformatf("an[%0d]", k), 32'(a), 32'(m_an[k]));
        check($sformatf("seg[%0d]", k), 32'(s), 32'(m_seg[k]));
    endtask

    task automatic cycle();
        m_step(0);
        m_step(1);
        @(posedge clk);
        #1;
        compare_dut(0, dig0, run0, done0, roll0, an0, seg0);
        compare_dut(1, dig1, run1, done1, roll1, an1, seg1);
        roll_seen = roll_seen | roll0 | roll1;
    endtask

    task automatic quiet();
        reset = 0; tick_count = 0; tick_adj = 0; scan_tick = 0; blink_lvl = 0;
        pause_tgl = 0; clear = 0; adj = 0; sel = 0; dir = 0;
    endtask

    task automatic do_reset();
        quiet();
        reset = 1;
        cycle();
        reset = 0;
        roll_seen = 1'b0;
    endtask

    task automatic adj_pulses(input logic [1:0] s, input int n);
        sel = s;
        tick_adj = 1;
        repeat (n) cycle();
        tick_adj = 0;
    endtask

    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];

    initial begin
        quiet();
        roll_seen = 1'b0;
        do_reset();
        check("reset digits", 32'(dig0), 32'h0);
        check("reset an", 32'(an0), 32'hF);
        check("reset seg", 32'(seg0), 32'h7F);
        check("reset running", 32'(run0), 32'h1);

        // 60 ticks with gaps
        for (int i = 0; i < 60; i++) begin
            tick_count = 1; cycle();
            tick_count = 0; cycle();
        end
        check("60 ticks", 32'(dig0), 32'h0100);
        check("60 ticks running", 32'(run0), 32'h1);
        check("no rollover", 32'(roll_seen), 32'h0);

        // Up to terminal, then one more
        tick_count = 1;
        repeat (3599 - 60) cycle();
        check("3599 ticks", 32'(dig0), 32'h5959);
        cycle();
        tick_count = 0;
        check("stop at terminal", 32'(dig0), 32'h5959);
        check("done set", 32'(done0), 32'h1);
        check("wrap to zero", 32'(dig1), 32'h0000);
        check("rollover pulse", 32'(roll1), 32'h1);
        cycle();
        check("rollover one cycle", 32'(roll1), 32'h0);
        clear = 1; cycle(); clear = 0;
        check("clear digits", 32'(dig0), 32'h0);
        check("clear to paused", 32'({run0, done0}), 32'h0);
        pause_tgl = 1; tick_count = 1; cycle(); pause_tgl = 0; tick_count = 0;
        check("toggle resumes", 32'(run0), 32'h1);
        check("toggle tick dropped", 32'(dig0), 32'h0);

        // Down-count from zero
        do_reset();
        dir = 1; tick_count = 1; cycle(); tick_count = 0;
        check("down wrap", 32'(dig1), 32'h5959);
        check("down rollover", 32'(roll1), 32'h1);
        check("down stop done", 32'(done0), 32'h1);
        cycle();
        dir = 0;

        // Field adjust with tick_count held high
        do_reset();
        tick_count = 1; adj = 1; cycle();
        adj_pulses(2'd0, 58);
        adj_pulses(2'd1, 1);
        check("adj setup", 32'(dig0), 32'h0158);
        adj_pulses(2'd0, 3);
        check("adj sec wrap", 32'(dig0), 32'h0101);
        adj_pulses(2'd1, 58);
        check("adj min set", 32'(dig0), 32'h5901);
        adj_pulses(2'd1, 1);
        check("adj min wrap", 32'(dig0), 32'h0001);
        adj_pulses(2'd2, 5);
        check("adj sel none", 32'(dig0), 32'h0001);
        tick_count = 0; adj = 0; cycle();
        check("adj exit run", 32'(run0), 32'h1);

        // Display scan at 12:34
        do_reset();
        adj = 1; cycle();
        adj_pulses(2'd0, 34);
        adj_pulses(2'd1, 12);
        adj = 0; sel = 0; cycle();
        check("scan value", 32'(dig0), 32'h1234);
        exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_seg = '{~7'h4F, ~7'h5B, ~7'h06, ~7'h66};
        for (int i = 0; i < 4; i++) begin
            scan_tick = 1; cycle(); scan_tick = 0;
            check($sformatf("scan an %0d", i), 32'(an0), 32'(exp_an[i]));
            check($sformatf("scan seg %0d", i), 32'(seg0), 32'(exp_seg[i]));
        end
        adj = 1; sel = 1; blink_lvl = 1;
        exp_seg = '{~7'h4F, 7'h7F, 7'h7F, ~7'h66};
        for (int i = 0; i < 4; i++) begin
            scan_tick = 1; cycle(); scan_tick = 0;
            check($sformatf("blink seg %0d", i), 32'(seg0), 32'(exp_seg[i]));
        end
        adj = 0; blink_lvl = 0; cycle();

        // Reset mid-count and during adjust
        tick_count = 1; scan_tick = 1; repeat (37) cycle();
        do_reset();
        check("reset mid-count", 32'({dig0, run0, done0, roll0, an0, seg0}),
              32'({16'h0, 1'b1, 1'b0, 1'b0, 4'hF, 7'h7F}));
        adj = 1; cycle();
        adj_pulses(2'd1, 7);
        scan_tick = 1; cycle(); scan_tick = 0;
        do_reset();
        check("reset in adjust", 32'({dig0, run0, done0, roll0, an0, seg0}),
              32'({16'h0, 1'b1, 1'b0, 1'b0, 4'hF, 7'h7F}));

        // Randomized traffic
        for (int c = 0; c < 6000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            tick_count = ($urandom_range(0, 1) == 0);
            tick_adj   = ($urandom_range(0, 2) == 0);
            scan_tick  = ($urandom_range(0, 3) == 0);
            blink_lvl  = $urandom_range(0, 1) != 0;
            pause_tgl  = ($urandom_range(0, 19) == 0);
            clear      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 39) == 0) adj = ~adj;
            if ($urandom_range(0, 7) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0) dir = ~dir;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
